seg7_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller that shares one seg7 decoder and one set of segment pins among NUM_DIGITS common-cathode digits.
- Accepts a packed BCD word over a valid/ready handshake and double-buffers it. New data only takes effect at a frame boundary, so a displayed frame never tears.
- Drives the BCD nibble into seg7, plus one-hot digit enables, a segment blank strobe and a frame pulse.
- Runs directly off the 1 kHz chip clock.

---
 rtl/seg7_scan_ctrl_if.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// Load handshake between a BCD data source and the seg7 scan controller.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic                    load_valid;
  logic [4*NUM_DIGITS-1:0] load_data;
  logic                    load_ready;

  modport master (output load_valid, output load_data, input  load_ready);
  modport slave  (input  load_valid, input  load_data, output load_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seg7 scan controller: one decoder shared by NUM_DIGITS digits,
// double-buffered BCD load that only takes effect at a frame boundary.

// One digit of the leading-zero chain: passes "all higher digits are zero" down.
module seg7_lz_lane #(
  parameter bit IS_LSD = 1'b0
) (
  input  logic [3:0] i_nib,
  input  logic       i_upper_zero,
  input  logic       i_blank_lz,
  output logic       o_zero,
  output logic       o_blank
);
  assign o_zero  = i_upper_zero & (i_nib == 4'h0);
  assign o_blank = i_blank_lz & o_zero & ~IS_LSD;
endmodule

module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 4,
  parameter int GAP        = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  blank_lz,
  seg7_scan_ctrl_if.slave       ld,
  output logic [3:0]            bcd_out,
  output logic                  seg_blank,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  frame_start
);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int TMAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

  typedef enum logic [1:0] {S_OFF, S_ON, S_GAP} state_t;

  state_t                       r_state, w_state_n;
  logic [IW-1:0]                r_idx, w_idx_n, w_idx_inc;
  logic [TW-1:0]                r_tcnt, w_tcnt_n;
  logic [NUM_DIGITS-1:0][3:0]   r_active, r_pending;
  logic                         r_pend_vld;
  logic                         w_boundary, w_load, w_last;
  logic [NUM_DIGITS:0]          w_zchain;
  logic [NUM_DIGITS-1:0]        w_lz;

  assign ld.load_ready = ~r_pend_vld;
  assign w_load        = ld.load_valid & ~r_pend_vld;
  assign w_last        = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_idx_inc     = w_last ? '0 : r_idx + 1'b1;

  // Zero-suppression chain runs from the most significant digit downward.
  assign w_zchain[NUM_DIGITS] = 1'b1;
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
    seg7_lz_lane #(.IS_LSD(k == 0)) u_lane (
      .i_nib        (r_active[k]),
      .i_upper_zero (w_zchain[k+1]),
      .i_blank_lz   (blank_lz),
      .o_zero       (w_zchain[k]),
      .o_blank      (w_lz[k])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_OFF;
      r_idx      <= '0;
      r_tcnt     <= '0;
      r_active   <= '0;
      r_pending  <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_tcnt  <= w_tcnt_n;
      // Copy and load are exclusive: a copy needs pending full, a load needs it empty.
      if (w_boundary && r_pend_vld) begin
        r_active   <= r_pending;
        r_pend_vld <= 1'b0;
      end else if (w_load) begin
        r_pending  <= ld.load_data;
        r_pend_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_idx_n     = r_idx;
    w_tcnt_n    = r_tcnt;
    w_boundary  = 1'b0;
    digit_sel   = '0;
    seg_blank   = 1'b1;
    bcd_out     = 4'h0;
    frame_start = 1'b0;

    if (!enable) begin
      w_state_n = S_OFF;
      w_idx_n   = '0;
      w_tcnt_n  = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_n  = S_ON;
          w_idx_n    = '0;
          w_tcnt_n   = '0;
          w_boundary = 1'b1;
        end
        S_ON: begin
          if (r_tcnt == TW'(DWELL - 1)) begin
            w_tcnt_n = '0;
            if (GAP == 0) begin
              w_idx_n    = w_idx_inc;
              w_boundary = w_last;
            end else begin
              w_state_n = S_GAP;
            end
          end else begin
            w_tcnt_n = r_tcnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_tcnt == TW'(GAP - 1)) begin
            w_tcnt_n   = '0;
            w_idx_n    = w_idx_inc;
            w_state_n  = S_ON;
            w_boundary = w_last;
          end else begin
            w_tcnt_n = r_tcnt + 1'b1;
          end
        end
        default: w_state_n = S_OFF;
      endcase
    end

    case (r_state)
      S_ON: begin
        digit_sel   = SEL_ONE << r_idx;
        bcd_out     = r_active[r_idx];
        seg_blank   = w_lz[r_idx];
        frame_start = (r_idx == '0) && (r_tcnt == '0);
      end
      S_GAP:   bcd_out = r_active[r_idx];
      default: ;
    endcase
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: default instance (4 digits, DWELL 4, GAP 1) and a
// fast instance (DWELL 1, GAP 0), both checked against a frame-position model.
module tb_seg7_scan_ctrl;
  logic        clock = 1'b0, reset = 1'b0, enable = 1'b0, blank_lz = 1'b0;
  logic        lv = 1'b0;
  logic [15:0] ldat = '0;
  logic [3:0]  bcd_a, sel_a, bcd_b, sel_b;
  logic        blank_a, fs_a, blank_b, fs_b;
  int          n_chk = 0, n_fail = 0;

  seg7_scan_ctrl_if #(.NUM_DIGITS(4)) ifa ();
  seg7_scan_ctrl_if #(.NUM_DIGITS(4)) ifb ();
  assign ifa.load_valid = lv;
  assign ifa.load_data  = ldat;
  assign ifb.load_valid = lv;
  assign ifb.load_data  = ldat;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .DWELL(4), .GAP(1)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .blank_lz(blank_lz), .ld(ifa),
    .bcd_out(bcd_a), .seg_blank(blank_a), .digit_sel(sel_a), .frame_start(fs_a));
  seg7_scan_ctrl #(.NUM_DIGITS(4), .DWELL(1), .GAP(0)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .blank_lz(blank_lz), .ld(ifb),
    .bcd_out(bcd_b), .seg_blank(blank_b), .digit_sel(sel_b), .frame_start(fs_b));

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: scanning flag plus position within the frame; digit/phase come from division.
  typedef struct {bit on; int pos; logic [15:0] act; logic [15:0] pend; bit pv;} mst_t;
  mst_t ma, mb;

  function automatic mst_t step(mst_t s, bit en, bit v, logic [15:0] d, int per);
    mst_t n = s;
    bit   bnd = 1'b0;
    if (v && !s.pv) begin n.pend = d; n.pv = 1'b1; end
    if (!en) begin n.on = 1'b0; n.pos = 0; end
    else if (!s.on) begin n.on = 1'b1; n.pos = 0; bnd = 1'b1; end
    else begin n.pos = (s.pos + 1) % per; bnd = (n.pos == 0); end
    if (bnd && s.pv) begin n.act = s.pend; n.pv = 1'b0; end
    return n;
  endfunction

  // {digit_sel, bcd, seg_blank, frame_start}
  function automatic logic [9:0] expo(mst_t s, bit blz, int dw, int gp);
    logic [15:0] sh;
    int dg, ph;
    logic lzb;
    if (!s.on) return {4'b0, 4'h0, 1'b1, 1'b0};
    dg  = s.pos / (dw + gp);
    ph  = s.pos % (dw + gp);
    sh  = s.act >> (4 * dg);
    lzb = blz && (dg > 0) && (sh == 16'h0);
    if (ph < dw) return {4'(1 << dg), sh[3:0], lzb, s.pos == 0};
    return {4'b0, sh[3:0], 1'b1, 1'b0};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      ma <= '{1'b0, 0, 16'h0, 16'h0, 1'b0};
      mb <= '{1'b0, 0, 16'h0, 16'h0, 1'b0};
    end else begin
      ma <= step(ma, enable, lv, ldat, 20);
      mb <= step(mb, enable, lv, ldat, 4);
    end
  end

  always @(negedge clock) begin
    chk("sb_a", {sel_a, bcd_a, blank_a, fs_a, ifa.load_ready}, {expo(ma, blank_lz, 4, 1), !ma.pv});
    chk("sb_b", {sel_b, bcd_b, blank_b, fs_b, ifb.load_ready}, {expo(mb, blank_lz, 1, 0), !mb.pv});
  end

  // Hold valid until ready was seen; transfer happens on the following posedge.
  task automatic load(input logic [15:0] d, output int waited);
    bit ok = 1'b0;
    waited = 0;
    lv = 1'b1; ldat = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (ifa.load_ready) ok = 1'b1;
      @(posedge clock); #1;
      waited++;
    end
    lv = 1'b0;
    if (!ok) chk("load_timeout", 0, 1);
  endtask

  typedef struct {logic [15:0] data; bit blz; logic [3:0] mask;} vec_t;
  vec_t vt[8];

  initial begin
    int w;
    bit found;
    logic [3:0]  mask;
    logic [15:0] nib;

    vt[0] = '{16'h1234, 1'b1, 4'b0000};
    vt[1] = '{16'h0050, 1'b1, 4'b1100};
    vt[2] = '{16'h0000, 1'b1, 4'b1110};
    vt[3] = '{16'h0000, 1'b0, 4'b0000};
    vt[4] = '{16'h0400, 1'b1, 4'b1000};
    vt[5] = '{16'h00A0, 1'b1, 4'b1100};
    vt[6] = '{16'hF00E, 1'b1, 4'b0000};
    vt[7] = '{16'h0009, 1'b1, 4'b1110};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", ifa.load_ready, 1);
    chk("rst_out", {sel_a, blank_a, bcd_a, fs_a}, {4'b0, 1'b1, 4'h0, 1'b0});
    reset = 1'b1;

    @(posedge clock); #1;
    enable = 1'b1;
    @(negedge clock);
    chk("off_first", sel_a, 4'b0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      chk("start_a", {sel_a, fs_a, bcd_a},
          {((c % 5) < 4) ? 4'(1 << ((c / 5) % 4)) : 4'b0, (c % 20) == 0, 4'h0});
      chk("start_b", {sel_b, fs_b}, {4'(1 << (c % 4)), (c % 4) == 0});
    end

    foreach (vt[r]) begin
      blank_lz = vt[r].blz;
      load(vt[r].data, w);
      @(negedge clock);
      chk("ready_drop", ifa.load_ready, 0);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
        if (ifa.load_ready) found = 1'b1;
        else @(negedge clock);
      end
      chk("boundary_fs", {found, fs_a}, 2'b11);
      mask = '0; nib = '0;
      for (int c = 0; c < 20; c++) begin
        if (c > 0) @(negedge clock);
        for (int k = 0; k < 4; k++)
          if (sel_a == 4'(1 << k)) begin mask[k] = blank_a; nib[4*k +: 4] = bcd_a; end
      end
      chk("lz_mask", mask, vt[r].mask);
      chk("digits", nib, vt[r].data);
    end

    blank_lz = 1'b0;
    load(16'h1111, w);
    load(16'h2222, w);
    chk("b2b_stall", w > 1, 1);
    @(negedge clock);
    chk("b2b_first", {sel_a, bcd_a}, {4'b0001, 4'h1});
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (fs_a) found = 1'b1;
    end
    chk("b2b_second", {found, sel_a, bcd_a}, {1'b1, 4'b0001, 4'h2});

    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (sel_a == 4'b0100) found = 1'b1;
    end
    enable = 1'b0;
    @(negedge clock);
    chk("en_drop", {found, sel_a, blank_a}, {1'b1, 4'b0, 1'b1});
    enable = 1'b1;
    @(negedge clock);
    chk("en_restart", {sel_a, fs_a, sel_b, fs_b}, {4'b0001, 1'b1, 4'b0001, 1'b1});

    load(16'h9876, w);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async", {sel_a, blank_a, ifa.load_ready, sel_b}, {4'b0, 1'b1, 1'b1, 4'b0});
    @(posedge clock); #1;
    reset = 1'b1;
    nib = '0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clock);
      for (int k = 0; k < 4; k++)
        if (sel_a == 4'(1 << k)) nib[4*k +: 4] = bcd_a;
    end
    chk("pend_discard", {nib, ifa.load_ready}, {16'h0, 1'b1});

    for (int c = 0; c < 400; c++) begin
      @(posedge clock); #1;
      enable   = ($urandom % 12) != 0;
      blank_lz = $urandom % 2;
      lv       = $urandom % 2;
      if (lv) ldat = 16'($urandom);
      if (($urandom % 150) == 0) begin
        reset = 1'b0; #2; reset = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
